// File: rtl/port_rd_ctrl_pkg.sv
// Shared constants and FSM state type for the per-port read controller.
package port_rd_ctrl_pkg;

    localparam int NQ    = 8;
    localparam int QW    = 3;
    localparam int LEN_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_POP,
        ST_RD,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/port_rd_wrr_sel.sv
// WRR mask state plus masked lowest-index queue selection.
module port_rd_wrr_sel
    import port_rd_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          next_i,
    input  logic          wrr_en_i,
    input  logic [NQ-1:0] queue_available_i,
    output logic [QW-1:0] sel_o
);

    logic [NQ-1:0] mask_q, mask_d;
    logic [QW-1:0] start_q, start_d;
    logic [QW-1:0] end_q, end_d;
    logic [NQ-1:0] masked;
    logic [NQ-1:0] fixed;

    always_comb begin
        mask_d  = mask_q;
        start_d = start_q;
        end_d   = end_q;
        if (next_i) begin
            if (start_q != end_q) begin
                mask_d[start_q] = 1'b0;
                start_d         = start_q + QW'(1);
            end else if (end_q == '0) begin
                mask_d  = '1;
                start_d = '0;
                end_d   = QW'(NQ - 1);
            end else begin
                // New round re-enables queues 0..old end; the window then shrinks by one.
                mask_d  = 8'hFF >> (QW'(NQ - 1) - end_q);
                start_d = '0;
                end_d   = end_q - QW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '1;
            start_q <= '0;
            end_q   <= QW'(NQ - 1);
        end else begin
            mask_q  <= mask_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    // An empty masked set falls back to the raw availability vector.
    always_comb begin
        masked = wrr_en_i ? (mask_q & queue_available_i) : queue_available_i;
        fixed  = (masked == '0) ? queue_available_i : masked;
        sel_o  = '0;
        for (int i = NQ - 1; i >= 0; i--) begin
            if (fixed[i]) sel_o = QW'(i);
        end
    end

endmodule

// File: rtl/port_rd_ctrl.sv
// Per-port read controller: select queue, pop descriptor, stream word reads to the SRAM arbiter.
module port_rd_ctrl
    import port_rd_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             port_ready,
    input  logic             wrr_en,
    input  logic [NQ-1:0]    queue_available,
    output logic             pop_req,
    output logic [QW-1:0]    pop_qid,
    input  logic             pop_ack,
    input  logic [LEN_W-1:0] pop_len,
    output logic             rd_req,
    input  logic             rd_gnt,
    output logic             rd_last,
    output logic             pkt_done,
    output logic             busy
);

    rd_state_e        state_q, state_d;
    logic [QW-1:0]    qid_q, qid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [QW-1:0]    sel;

    port_rd_wrr_sel u_wrr_sel (
        .clk               (clk),
        .rst_n             (rst_n),
        .next_i            (pkt_done),
        .wrr_en_i          (wrr_en),
        .queue_available_i (queue_available),
        .sel_o             (sel)
    );

    // Handshakes: pop_req holds with a stable pop_qid until pop_ack; rd_req holds until the final word is granted.
    always_comb begin
        state_d  = state_q;
        qid_d    = qid_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pop_req  = 1'b0;
        rd_req   = 1'b0;
        rd_last  = 1'b0;
        pkt_done = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (port_ready && (|queue_available)) state_d = ST_SEL;
            end
            ST_SEL: begin
                if (|queue_available) begin
                    qid_d   = sel;
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                pop_req = 1'b1;
                if (pop_ack) begin
                    len_d   = (pop_len == '0) ? LEN_W'(1) : pop_len;
                    cnt_d   = '0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                rd_req  = 1'b1;
                rd_last = (cnt_q == len_q - LEN_W'(1));
                if (rd_gnt) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (rd_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pkt_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            qid_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            qid_q   <= qid_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop_qid = qid_q;

endmodule

// File: tb/tb_port_rd_ctrl.sv
// Bench for port_rd_ctrl: randomized packets checked against a window-based WRR reference model.
module tb_port_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       port_ready;
    logic       wrr_en;
    logic [7:0] queue_available;
    logic       pop_req;
    logic [2:0] pop_qid;
    logic       pop_ack;
    logic [6:0] pop_len;
    logic       rd_req;
    logic       rd_gnt;
    logic       rd_last;
    logic       pkt_done;
    logic       busy;

    int n_total;
    int n_pass;
    logic [2:0] exp_q[$];

    // Reference WRR state: eligible queues are those in [m_start, m_hi].
    int m_start;
    int m_end;
    int m_hi;

    port_rd_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .port_ready      (port_ready),
        .wrr_en          (wrr_en),
        .queue_available (queue_available),
        .pop_req         (pop_req),
        .pop_qid         (pop_qid),
        .pop_ack         (pop_ack),
        .pop_len         (pop_len),
        .rd_req          (rd_req),
        .rd_gnt          (rd_gnt),
        .rd_last         (rd_last),
        .pkt_done        (pkt_done),
        .busy            (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_start = 0;
        m_end   = 7;
        m_hi    = 7;
    endfunction

    function automatic void model_advance();
        if (m_start < m_end) begin
            m_start++;
        end else if (m_end == 0) begin
            m_start = 0;
            m_end   = 7;
            m_hi    = 7;
        end else begin
            m_hi    = m_end;
            m_start = 0;
            m_end   = m_end - 1;
        end
    endfunction

    function automatic int model_sel(input logic [7:0] avail, input logic wrr);
        for (int q = 0; q < 8; q++) begin
            if (avail[q] && (!wrr || (q >= m_start && q <= m_hi))) return q;
        end
        for (int q = 0; q < 8; q++) begin
            if (avail[q]) return q;
        end
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the DUT in IDLE and port_ready = 1.
    // gnt_mode: 0 = grant every cycle, 1 = every other cycle, 2 = random.
    // abort_at >= 0: assert reset after that many grants.
    task automatic run_pkt(input int len, input int ack_dly, input int gnt_mode, input int abort_at);
        int e_qid;
        int words;
        int grants;
        int cnt;
        logic [7:0] avail_save;
        exp_q.push_back(3'(model_sel(queue_available, wrr_en)));
        cnt = 0;
        while (!pop_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("pop_latency", cnt, 2);
        if (!pop_req) begin
            void'(exp_q.pop_front());
            return;
        end
        e_qid = int'(exp_q.pop_front());
        check("pop_qid", pop_qid, e_qid);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check("pop_req_hold", pop_req, 1);
            check("pop_qid_hold", pop_qid, e_qid);
        end
        pop_ack = 1'b1;
        pop_len = len[6:0];
        @(negedge clk);
        pop_ack = 1'b0;
        pop_len = 7'($urandom);
        check("pop_req_drop", pop_req, 0);
        check("rd_req_start", rd_req, 1);
        words      = (len == 0) ? 1 : len;
        grants     = 0;
        cnt        = 0;
        avail_save = queue_available;
        while (grants < words && cnt < 1000) begin
            if (abort_at >= 0 && grants == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_rd_req", rd_req, 0);
                check("rst_pop_req", pop_req, 0);
                check("rst_pkt_done", pkt_done, 0);
                check("rst_rd_last", rd_last, 0);
                check("rst_pop_qid", pop_qid, 0);
                model_reset();
                @(negedge clk);
                rd_gnt          = 1'b0;
                queue_available = avail_save;
                port_ready      = 1'b1;
                rst_n           = 1'b1;
                return;
            end
            check("rd_req_hold", rd_req, 1);
            check("pkt_done_early", pkt_done, 0);
            check("rd_last", rd_last, (grants == words - 1) ? 1 : 0);
            case (gnt_mode)
                0:       rd_gnt = 1'b1;
                1:       rd_gnt = (cnt % 2) == 1;
                default: rd_gnt = 1'($urandom_range(0, 1));
            endcase
            port_ready      = 1'($urandom_range(0, 1));
            queue_available = 8'($urandom);
            @(negedge clk);
            cnt++;
            if (rd_gnt) grants++;
        end
        if (grants < words) begin
            check("grant_timeout", grants, words);
            return;
        end
        rd_gnt = 1'($urandom_range(0, 1));
        check("pkt_done", pkt_done, 1);
        check("rd_req_drop", rd_req, 0);
        check("busy_done", busy, 1);
        model_advance();
        queue_available = avail_save;
        port_ready      = 1'b1;
        @(negedge clk);
        rd_gnt = 1'b0;
        check("pkt_done_pulse", pkt_done, 0);
        check("idle_gap", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_total         = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        port_ready      = 1'b0;
        wrr_en          = 1'b0;
        queue_available = 8'h00;
        pop_ack         = 1'b0;
        pop_len         = 7'd0;
        rd_gnt          = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_pop_req", pop_req, 0);
        check("reset_rd_req", rd_req, 0);
        check("reset_rd_last", rd_last, 0);
        check("reset_pkt_done", pkt_done, 0);
        check("reset_pop_qid", pop_qid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Strict priority: queue 1 is always the lowest available index.
        wrr_en          = 1'b0;
        queue_available = 8'h0A;
        port_ready      = 1'b1;
        repeat (4) run_pkt($urandom_range(1, 4), 0, 0, -1);

        // Full WRR cycle (36 packets) and the start of the next.
        do_reset();
        wrr_en          = 1'b1;
        queue_available = 8'hFF;
        repeat (40) run_pkt(1, 0, 0, -1);

        // Mask fallback after three packets.
        do_reset();
        repeat (3) run_pkt(1, 0, 0, -1);
        queue_available = 8'h03;
        run_pkt(1, 0, 0, -1);
        queue_available = 8'hFF;

        // Lengths: alternating grants, zero length, maximum length.
        run_pkt(5, 0, 1, -1);
        run_pkt(0, 0, 0, -1);
        run_pkt(127, 0, 2, -1);

        // Delayed pop_ack, then stray handshakes while idle.
        run_pkt(3, 4, 2, -1);
        port_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_gnt  = 1'($urandom_range(0, 1));
            pop_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stray_busy", busy, 0);
            check("stray_pop_req", pop_req, 0);
            check("stray_rd_req", rd_req, 0);
        end
        rd_gnt     = 1'b0;
        pop_ack    = 1'b0;
        port_ready = 1'b1;

        // Reset in the middle of a 4-word packet, then selection restarts from a full mask.
        run_pkt(2, 0, 0, -1);
        run_pkt(4, 0, 0, 2);
        run_pkt(1, 0, 0, -1);
        run_pkt(1, 0, 0, -1);

        // Random mix of modes, availability, lengths and ack delays.
        for (int i = 0; i < 40; i++) begin
            wrr_en          = 1'($urandom_range(0, 3) != 0);
            queue_available = 8'($urandom_range(1, 255));
            run_pkt($urandom_range(0, 8), $urandom_range(0, 3), 2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
